multi_line_trigger: RTL and testbench

MULTI_LINE_TRIGGER -- requirements
Module: multi_line_trigger

---
 rtl/multi_line_trigger.sv | 177 +++++++++++++++++
 tb/tb_multi_line_trigger.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_line_trigger.sv
// multi_line_trigger
//   Multi-channel periodic / one-shot trigger generator. Each channel runs a
//   CW-bit counter 0..P (P = active period) and drives its line high for the
//   last W counts of every period (W = active width), one cycle late through
//   a register. Configuration inputs are quasi-static. They are double-sampled
//   and accepted only when two consecutive samples agree. They are applied
//   only while idle or at the period boundary, so a running period is never
//   disturbed.
//
// Ports
//   clk8m       in   sole clock
//   rst_n       in   asynchronous active-low reset
//   cfg_period  in   NCH*CW  per-channel period P, channel k at [k*CW +: CW]
//   cfg_width   in   NCH*CW  per-channel pulse width W, same packing
//   ch_en       in   NCH     per-channel enable
//   one_shot    in   NCH     per-channel mode (0 free-run, 1 one-shot)
//   arm         in   NCH     per-channel single-cycle start (one-shot only)
//   line        out  NCH     registered trigger outputs
//   busy        out  NCH     high while the channel counter is running
module multi_line_trigger #(
  parameter int NCH = 2,
  parameter int CW  = 16
) (
  input  logic              clk8m,
  input  logic              rst_n,
  input  logic [NCH*CW-1:0] cfg_period,
  input  logic [NCH*CW-1:0] cfg_width,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    one_shot,
  input  logic [NCH-1:0]    arm,
  output logic [NCH-1:0]    line,
  output logic [NCH-1:0]    busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CW-1:0] per_d0_r;
    logic [CW-1:0] per_d1_r;
    logic [CW-1:0] wid_d0_r;
    logic [CW-1:0] wid_d1_r;
    logic [CW-1:0] per_stg_r;
    logic [CW-1:0] wid_stg_r;
    logic [CW-1:0] per_act_r;
    logic [CW-1:0] wid_act_r;
    logic          mode_act_r;
    logic [CW-1:0] cnt_r;
    state_t        state_r;
    logic          line_r;

    logic          at_end_s;
    logic          upd_s;
    logic [CW-1:0] per_nxt_s;
    logic          mode_nxt_s;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          line_nxt_s;

    // Double-sample configuration; stage a field only when both samples agree.
    always_ff @(posedge clk8m or negedge rst_n) begin
      if (!rst_n) begin
        per_d0_r  <= {CW{1'b0}};
        per_d1_r  <= {CW{1'b0}};
        wid_d0_r  <= {CW{1'b0}};
        wid_d1_r  <= {CW{1'b0}};
        per_stg_r <= {CW{1'b0}};
        wid_stg_r <= {CW{1'b0}};
      end else begin
        per_d0_r <= cfg_period[k*CW +: CW];
        per_d1_r <= per_d0_r;
        wid_d0_r <= cfg_width[k*CW +: CW];
        wid_d1_r <= wid_d0_r;
        if (per_d0_r == per_d1_r) begin
          per_stg_r <= per_d1_r;
        end
        if (wid_d0_r == wid_d1_r) begin
          wid_stg_r <= wid_d1_r;
        end
      end
    end

    // Update point: idle, or last count of the running period.
    always_comb begin
      at_end_s   = (state_r == ST_RUN) && (cnt_r == per_act_r);
      upd_s      = (state_r == ST_IDLE) || at_end_s;
      per_nxt_s  = upd_s ? per_stg_r : per_act_r;
      mode_nxt_s = upd_s ? one_shot[k] : mode_act_r;
    end

    // Active period/width/mode only change at an update point.
    always_ff @(posedge clk8m or negedge rst_n) begin
      if (!rst_n) begin
        per_act_r  <= {CW{1'b0}};
        wid_act_r  <= {CW{1'b0}};
        mode_act_r <= 1'b0;
      end else if (upd_s) begin
        per_act_r  <= per_stg_r;
        wid_act_r  <= wid_stg_r;
        mode_act_r <= one_shot[k];
      end
    end

    // Next-state and counter: the values that take effect at this edge
    // (per_nxt_s/mode_nxt_s) decide whether a new period starts.
    always_comb begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CW{1'b0}};
      if (!ch_en[k] || (per_nxt_s == {CW{1'b0}})) begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            // Free-run starts on its own; one-shot waits for arm.
            if (!mode_nxt_s || arm[k]) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_IDLE;
            end
            cnt_nxt_s = {CW{1'b0}};
          end
          ST_RUN: begin
            if (!at_end_s) begin
              state_nxt_s = ST_RUN;
              cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (!mode_nxt_s) begin
              state_nxt_s = ST_RUN;
              cnt_nxt_s   = {CW{1'b0}};
            end else begin
              state_nxt_s = ST_IDLE;
              cnt_nxt_s   = {CW{1'b0}};
            end
          end
          default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
          end
        endcase
      end
    end

    // Line window: last W counts of the period, with P - W saturating at
    // "whole period" when W exceeds P.
    always_comb begin
      line_nxt_s = 1'b0;
      if (ch_en[k] && (state_r == ST_RUN)) begin
        if (wid_act_r > per_act_r) begin
          line_nxt_s = 1'b1;
        end else begin
          line_nxt_s = (cnt_r > (per_act_r - wid_act_r));
        end
      end else begin
        line_nxt_s = 1'b0;
      end
    end

    // State, counter and output registers.
    always_ff @(posedge clk8m or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
        cnt_r   <= {CW{1'b0}};
        line_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        line_r  <= line_nxt_s;
      end
    end

    assign line[k] = line_r;
    assign busy[k] = (state_r == ST_RUN);
  end

endmodule

// File: tb/tb_multi_line_trigger.sv
module tb_multi_line_trigger;
  logic        clk8m;
  logic        rst_n;
  logic [31:0] cfg_period;
  logic [31:0] cfg_width;
  logic [1:0]  ch_en;
  logic [1:0]  one_shot;
  logic [1:0]  arm;
  logic [1:0]  line;
  logic [1:0]  busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected edge events, encoded as cycle*2 + new value, one queue per output bit.
  int q_l0[$];
  int q_b0[$];
  int q_l1[$];
  int q_b1[$];

  multi_line_trigger #(.NCH(2), .CW(16)) dut (
    .clk8m(clk8m), .rst_n(rst_n), .cfg_period(cfg_period), .cfg_width(cfg_width),
    .ch_en(ch_en), .one_shot(one_shot), .arm(arm), .line(line), .busy(busy)
  );

  initial clk8m = 1'b0;
  always #5 clk8m = ~clk8m;

  // Cycle number: count of rising edges since the last reset release.
  always @(posedge clk8m) cyc <= rst_n ? cyc + 1 : 0;

  task automatic push(input int ch, input int sig, input int c, input int v);
    case (ch * 2 + sig)
      0: q_l0.push_back(c * 2 + v);
      1: q_b0.push_back(c * 2 + v);
      2: q_l1.push_back(c * 2 + v);
      default: q_b1.push_back(c * 2 + v);
    endcase
  endtask

  task automatic pulses(input int ch, input int rise, input int w, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      push(ch, 0, rise + i * per, 1);
      push(ch, 0, rise + i * per + w, 0);
    end
  endtask

  task automatic check_ev(input int ch, input int sig, input int v);
    int code;
    int e;
    bit got;
    code = cyc * 2 + v;
    got  = 1'b0;
    e    = 0;
    case (ch * 2 + sig)
      0: if (q_l0.size() > 0) begin e = q_l0.pop_front(); got = 1'b1; end
      1: if (q_b0.size() > 0) begin e = q_b0.pop_front(); got = 1'b1; end
      2: if (q_l1.size() > 0) begin e = q_l1.pop_front(); got = 1'b1; end
      default: if (q_b1.size() > 0) begin e = q_b1.pop_front(); got = 1'b1; end
    endcase
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ev_ch%0d_%s unexpected edge: got cyc=%0d val=%0d, required no edge",
               ch, sig ? "busy" : "line", cyc, v);
    end else if (e != code) begin
      failures++;
      $display("FAIL ev_ch%0d_%s: got cyc=%0d val=%0d, required cyc=%0d val=%0d",
               ch, sig ? "busy" : "line", cyc, v, e / 2, e % 2);
    end
  endtask

  task automatic leftover(input string name, input int sz, input int head);
    checks++;
    if (sz != 0) begin
      failures++;
      $display("FAIL %s missing edges: got %0d still pending (next cyc=%0d val=%0d), required 0",
               name, sz, head / 2, head % 2);
    end
  endtask

  task automatic end_chk(input string scen);
    leftover({scen, "_l0"}, q_l0.size(), (q_l0.size() > 0) ? q_l0[0] : 0);
    leftover({scen, "_b0"}, q_b0.size(), (q_b0.size() > 0) ? q_b0[0] : 0);
    leftover({scen, "_l1"}, q_l1.size(), (q_l1.size() > 0) ? q_l1[0] : 0);
    leftover({scen, "_b1"}, q_b1.size(), (q_b1.size() > 0) ? q_b1[0] : 0);
    q_l0.delete(); q_b0.delete(); q_l1.delete(); q_b1.delete();
  endtask

  task automatic direct(input string name, input logic [1:0] got, input logic [1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk8m);
      #1;
    end
  endtask

  task automatic start(input logic [15:0] p0, input logic [15:0] w0, input logic [15:0] p1,
                       input logic [15:0] w1, input logic [1:0] en, input logic [1:0] os);
    rst_n      = 1'b0;
    cfg_period = {p1, p0};
    cfg_width  = {w1, w0};
    ch_en      = en;
    one_shot   = os;
    arm        = 2'b00;
    repeat (3) @(posedge clk8m);
    @(negedge clk8m);
    rst_n = 1'b1;
  endtask

  // Monitor: every output edge is matched against the expected-edge queues.
  initial begin
    logic [1:0] pl;
    logic [1:0] pb;
    pl = 2'b00;
    pb = 2'b00;
    forever begin
      @(negedge clk8m);
      for (int ch = 0; ch < 2; ch++) begin
        if (line[ch] !== pl[ch]) check_ev(ch, 0, int'(line[ch]));
        if (busy[ch] !== pb[ch]) check_ev(ch, 1, int'(busy[ch]));
      end
      pl = line;
      pb = busy;
    end
  end

  initial begin
    rst_n      = 1'b0;
    cfg_period = 32'd0;
    cfg_width  = 32'd0;
    ch_en      = 2'b00;
    one_shot   = 2'b00;
    arm        = 2'b00;
    repeat (2) @(posedge clk8m);
    #1;
    direct("reset_line", line, 2'b00);
    direct("reset_busy", busy, 2'b00);

    // Free-run ch0 P=99 W=10, ch1 P=29 W=3 concurrently.
    start(16'd99, 16'd10, 16'd29, 16'd3, 2'b11, 2'b00);
    push(0, 1, 4, 1); push(1, 1, 4, 1);
    pulses(0, 95, 10, 100, 5);
    pulses(1, 32, 3, 30, 17);
    push(0, 1, 521, 0); push(1, 1, 521, 0);
    to_cyc(520); ch_en = 2'b00;
    to_cyc(525); end_chk("freerun");

    // Period 99 -> 49 changed at cnt=30: current period finishes at 100 cycles.
    start(16'd99, 16'd10, 16'd0, 16'd0, 2'b01, 2'b00);
    push(0, 1, 4, 1);
    push(0, 0, 95, 1); push(0, 0, 105, 0);
    pulses(0, 145, 10, 50, 2);
    push(0, 1, 221, 0);
    to_cyc(34); cfg_period = {16'd0, 16'd49};
    to_cyc(220); ch_en = 2'b00;
    to_cyc(225); end_chk("perchg");

    // W=0 on ch0 never pulses; W=200 > P on ch1 is high the whole time.
    start(16'd99, 16'd0, 16'd99, 16'd200, 2'b11, 2'b00);
    push(0, 1, 4, 1); push(1, 1, 4, 1);
    push(1, 0, 5, 1); push(1, 0, 251, 0);
    push(0, 1, 251, 0); push(1, 1, 251, 0);
    to_cyc(250); ch_en = 2'b00;
    to_cyc(255); end_chk("widths");

    // One-shot P=19 W=5: arm, ignored re-arm at cnt=10, arm again after idle.
    start(16'd19, 16'd5, 16'd0, 16'd0, 2'b01, 2'b01);
    push(0, 1, 11, 1); push(0, 1, 31, 0);
    push(0, 0, 27, 1); push(0, 0, 32, 0);
    push(0, 1, 41, 1); push(0, 1, 61, 0);
    push(0, 0, 57, 1); push(0, 0, 62, 0);
    to_cyc(10); arm = 2'b01;
    to_cyc(11); arm = 2'b00;
    to_cyc(21); arm = 2'b01;
    to_cyc(22); arm = 2'b00;
    to_cyc(40); arm = 2'b01;
    to_cyc(41); arm = 2'b00;
    to_cyc(70); end_chk("oneshot");

    // Period toggling every cycle is never staged; once stable it is accepted.
    start(16'd0, 16'd2, 16'd0, 16'd0, 2'b01, 2'b00);
    push(0, 1, 24, 1);
    pulses(0, 33, 2, 10, 3);
    push(0, 1, 61, 0);
    for (int c = 0; c < 20; c++) begin
      to_cyc(c);
      cfg_period = {16'd0, (c % 2 == 0) ? 16'd9 : 16'd5};
    end
    to_cyc(20); cfg_period = {16'd0, 16'd9};
    to_cyc(60); ch_en = 2'b00;
    to_cyc(65); end_chk("glitch");

    // Reset at ch0 cnt=95 with line high; ch1 running with a different period.
    start(16'd99, 16'd10, 16'd29, 16'd3, 2'b11, 2'b00);
    push(0, 1, 4, 1); push(1, 1, 4, 1);
    push(0, 0, 95, 1); push(0, 0, 99, 0);
    pulses(1, 32, 3, 30, 3);
    push(0, 1, 99, 0); push(1, 1, 99, 0);
    to_cyc(99);
    rst_n = 1'b0;
    #1;
    direct("midreset_line", line, 2'b00);
    direct("midreset_busy", busy, 2'b00);
    repeat (3) @(posedge clk8m);
    end_chk("midreset");
    @(negedge clk8m);
    rst_n = 1'b1;
    push(0, 1, 4, 1); push(1, 1, 4, 1);
    push(0, 1, 21, 0); push(1, 1, 21, 0);
    to_cyc(20); ch_en = 2'b00;
    to_cyc(25); end_chk("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
